// File: rtl/ps2_key_decoder_pkg.sv
// Shared definitions for the PS/2 keyboard front end: scan codes, direction
// bit positions and the frame/decoder state encodings.
package ps2_defs;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  localparam int DIR_UP    = 3;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_LEFT  = 1;
  localparam int DIR_RIGHT = 0;

  typedef enum logic [1:0] {FR_IDLE, FR_DATA, FR_PARITY, FR_STOP} frame_state_t;
  typedef enum logic [1:0] {DEC_BASE, DEC_EXT, DEC_BRK, DEC_EXT_BRK} dec_state_t;

  // One-hot direction mask for an arrow scan code; zero for anything else.
  function automatic logic [3:0] arrow_onehot(input logic [7:0] code);
    arrow_onehot = '0;
    case (code)
      SC_UP:    arrow_onehot[DIR_UP]    = 1'b1;
      SC_DOWN:  arrow_onehot[DIR_DOWN]  = 1'b1;
      SC_LEFT:  arrow_onehot[DIR_LEFT]  = 1'b1;
      SC_RIGHT: arrow_onehot[DIR_RIGHT] = 1'b1;
      default:  ;
    endcase
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 byte receiver: synchronizers, ps2_clk glitch filter, 11-bit frame FSM
// with odd-parity/stop checking and a mid-frame idle timeout.
module ps2_rx
  import ps2_defs::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_error
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    clk_sync, dat_sync;
  logic          clk_filt, clk_filt_d;
  logic [FW-1:0] filt_cnt;
  logic          fall, frame_ok;
  frame_state_t  state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic          parity_bit;
  logic [TW-1:0] idle_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // The bus idles high, so resetting to 1 keeps reset release from faking a falling edge.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      clk_sync   <= 2'b11;
      dat_sync   <= 2'b11;
      clk_filt   <= 1'b1;
      clk_filt_d <= 1'b1;
      filt_cnt   <= '0;
    end else begin
      clk_sync   <= {clk_sync[0], ps2_clk};
      dat_sync   <= {dat_sync[0], ps2_dat};
      clk_filt_d <= clk_filt;
      if (clk_sync[1] == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_sync[1];
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign fall     = clk_filt_d & ~clk_filt;
  assign frame_ok = (^{shift_reg, parity_bit}) & dat_sync[1];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= FR_IDLE;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      parity_bit  <= 1'b0;
      idle_cnt    <= '0;
      rx_byte     <= '0;
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;
      if (state != FR_IDLE && clk_filt) idle_cnt <= idle_cnt + 1'b1;
      else                              idle_cnt <= '0;

      if (state != FR_IDLE && clk_filt && idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        frame_error <= 1'b1;
        state       <= FR_IDLE;
        idle_cnt    <= '0;
      end else if (fall) begin
        case (state)
          FR_IDLE: begin
            if (!dat_sync[1]) begin
              state   <= FR_DATA;
              bit_cnt <= '0;
            end else begin
              frame_error <= 1'b1;
            end
          end
          FR_DATA: begin
            shift_reg <= {dat_sync[1], shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= FR_PARITY;
          end
          FR_PARITY: begin
            parity_bit <= dat_sync[1];
            state      <= FR_STOP;
          end
          FR_STOP: begin
            if (frame_ok) begin
              rx_byte  <= shift_reg;
              rx_valid <= 1'b1;
            end else begin
              frame_error <= 1'b1;
            end
            state <= FR_IDLE;
          end
          default: state <= FR_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// Scan-code set 2 decoder for the 2048 game: turns received bytes into
// single-cycle start/direction pulses with typematic repeat suppressed.
module ps2_key_decoder
  import ps2_defs::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [3:0] direction,
  output logic       start,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_error
);

  dec_state_t state;
  logic       held_s;
  logic [3:0] held_arrow;
  logic [3:0] arrow;

  ps2_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clock      (clock),
    .resetn     (resetn),
    .ps2_clk    (ps2_clk),
    .ps2_dat    (ps2_dat),
    .rx_byte    (rx_byte),
    .rx_valid   (rx_valid),
    .frame_error(frame_error)
  );

  assign arrow = arrow_onehot(rx_byte);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= DEC_BASE;
      held_s     <= 1'b0;
      held_arrow <= '0;
      direction  <= '0;
      start      <= 1'b0;
    end else begin
      direction <= '0;
      start     <= 1'b0;
      // A broken frame abandons any prefix but keeps which keys are down.
      if (frame_error) begin
        state <= DEC_BASE;
      end else if (rx_valid) begin
        case (state)
          DEC_BASE: begin
            if (rx_byte == SC_EXT) begin
              state <= DEC_EXT;
            end else if (rx_byte == SC_BRK) begin
              state <= DEC_BRK;
            end else if (rx_byte == SC_S && !held_s) begin
              start  <= 1'b1;
              held_s <= 1'b1;
            end
          end
          DEC_EXT: begin
            if (rx_byte == SC_BRK) begin
              state <= DEC_EXT_BRK;
            end else begin
              state <= DEC_BASE;
              if ((arrow & held_arrow) == '0) begin
                direction  <= arrow;
                held_arrow <= held_arrow | arrow;
              end
            end
          end
          DEC_BRK: begin
            if (rx_byte == SC_S) held_s <= 1'b0;
            state <= DEC_BASE;
          end
          DEC_EXT_BRK: begin
            held_arrow <= held_arrow & ~arrow;
            state      <= DEC_BASE;
          end
          default: state <= DEC_BASE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: PS/2 frame driver, key-level
// reference model checked every cycle, directed scenarios plus random traffic.
module tb_ps2_key_decoder;

  localparam int TO   = 2000;
  localparam int HALF = 20;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [3:0] direction;
  logic       start;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       frame_error;

  ps2_key_decoder #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TO)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .ps2_clk    (ps2_clk),
    .ps2_dat    (ps2_dat),
    .direction  (direction),
    .start      (start),
    .rx_byte    (rx_byte),
    .rx_valid   (rx_valid),
    .frame_error(frame_error)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Expected receiver events, in order: a good byte or a frame error.
  typedef struct {
    bit         is_err;
    logic [7:0] b;
  } ev_t;
  ev_t evq[$];

  // Key-level model: pending prefixes, which keys are physically held.
  bit         m_ext, m_brk, m_held_s;
  bit   [3:0] m_held;
  logic [3:0] pend_dir;
  logic       pend_start;
  logic [7:0] last_byte;
  int         dir_cnt[4];
  int         start_cnt, err_cnt, valid_cnt;

  function automatic int arrow_bit(input logic [7:0] b);
    case (b)
      8'h75:   return 3;
      8'h72:   return 2;
      8'h6B:   return 1;
      8'h74:   return 0;
      default: return -1;
    endcase
  endfunction

  always @(negedge clock) begin
    if (!resetn) begin
      check("reset_outputs", 32'({direction, start, rx_byte, rx_valid, frame_error}), 32'h0);
      m_ext = 0; m_brk = 0; m_held_s = 0; m_held = '0;
      pend_dir = '0; pend_start = 1'b0; last_byte = 8'h00;
      evq.delete();
    end else begin
      check("direction", 32'(direction), 32'(pend_dir));
      check("start", 32'(start), 32'(pend_start));
      for (int i = 0; i < 4; i++) if (direction[i]) dir_cnt[i]++;
      if (start) start_cnt++;
      pend_dir = '0;
      pend_start = 1'b0;
      if (frame_error) begin
        err_cnt++;
        check("frame_error_expected", 32'(evq.size() > 0 && evq[0].is_err), 32'd1);
        if (evq.size() > 0 && evq[0].is_err) void'(evq.pop_front());
        m_ext = 0; m_brk = 0;
      end
      if (rx_valid) begin
        valid_cnt++;
        check("rx_valid_expected", 32'(evq.size() > 0 && !evq[0].is_err), 32'd1);
        if (evq.size() > 0 && !evq[0].is_err) begin
          ev_t ev;
          int  ab;
          ev = evq.pop_front();
          check("rx_byte", 32'(rx_byte), 32'(ev.b));
          last_byte = ev.b;
          ab = arrow_bit(ev.b);
          if (m_brk) begin
            if (m_ext) begin
              if (ab >= 0) m_held[ab] = 1'b0;
            end else if (ev.b == 8'h1B) begin
              m_held_s = 1'b0;
            end
            m_ext = 0; m_brk = 0;
          end else if (ev.b == 8'hF0) begin
            m_brk = 1;
          end else if (m_ext) begin
            if (ab >= 0 && !m_held[ab]) begin
              pend_dir[ab] = 1'b1;
              m_held[ab]   = 1'b1;
            end
            m_ext = 0;
          end else if (ev.b == 8'hE0) begin
            m_ext = 1;
          end else if (ev.b == 8'h1B && !m_held_s) begin
            pend_start = 1'b1;
            m_held_s   = 1'b1;
          end
        end
      end else begin
        check("rx_byte_hold", 32'(rx_byte), 32'(last_byte));
      end
    end
  end

  task automatic ps2_bit(input logic v);
    ps2_dat = v;
    repeat (HALF / 2) @(posedge clock);
    ps2_clk = 1'b0;
    repeat (HALF) @(posedge clock);
    ps2_clk = 1'b1;
    repeat (HALF / 2) @(posedge clock);
  endtask

  task automatic send_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int n);
    logic [10:0] f;
    logic        p;
    p = ~(^b);
    if (bad_par) p = ~p;
    f = {~bad_stop, p, b, 1'b0};
    for (int i = 0; i < n; i++) ps2_bit(f[i]);
    ps2_dat = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par = 0, input bit bad_stop = 0);
    ev_t ev;
    ev.is_err = bad_par | bad_stop;
    ev.b      = b;
    evq.push_back(ev);
    send_bits(b, bad_par, bad_stop, 11);
    repeat (60) @(posedge clock);
  endtask

  int s_dir[4];
  int s_start, s_err, s_valid;

  task automatic snap();
    for (int i = 0; i < 4; i++) s_dir[i] = dir_cnt[i];
    s_start = start_cnt; s_err = err_cnt; s_valid = valid_cnt;
  endtask

  task automatic delta(input string name, input int u, input int d, input int l, input int r,
                       input int s, input int e);
    check({name, "_up"},    32'(dir_cnt[3] - s_dir[3]), 32'(u));
    check({name, "_down"},  32'(dir_cnt[2] - s_dir[2]), 32'(d));
    check({name, "_left"},  32'(dir_cnt[1] - s_dir[1]), 32'(l));
    check({name, "_right"}, 32'(dir_cnt[0] - s_dir[0]), 32'(r));
    check({name, "_start"}, 32'(start_cnt - s_start),   32'(s));
    check({name, "_err"},   32'(err_cnt - s_err),       32'(e));
  endtask

  initial begin
    logic [7:0] pool [8];
    int         waited;
    ev_t        tev;
    pool = '{8'hE0, 8'hF0, 8'h1B, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h00};
    repeat (5) @(posedge clock);
    #2 resetn = 1'b1;
    repeat (20) @(posedge clock);

    // Up arrow make.
    snap();
    send_frame(8'hE0); send_frame(8'h75);
    delta("e0_75", 1, 0, 0, 0, 0, 0);
    check("e0_75_valid", 32'(valid_cnt - s_valid), 32'd2);

    // S press, typematic repeat, release, press again.
    snap();
    send_frame(8'h1B); send_frame(8'h1B);
    send_frame(8'hF0); send_frame(8'h1B); send_frame(8'h1B);
    delta("s_key", 0, 0, 0, 0, 2, 0);

    // Left make, repeat, break, make.
    snap();
    send_frame(8'hE0); send_frame(8'h6B);
    send_frame(8'hE0); send_frame(8'h6B);
    send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h6B);
    send_frame(8'hE0); send_frame(8'h6B);
    delta("left", 0, 0, 2, 0, 0, 0);

    // Bad parity leaves rx_byte alone; then right arrow while left is held.
    snap();
    send_frame(8'h75, 1'b1, 1'b0);
    check("rx_byte_after_bad", 32'(rx_byte), 32'h6B);
    check("bad_no_valid", 32'(valid_cnt - s_valid), 32'd0);
    send_frame(8'hE0); send_frame(8'h74);
    delta("parity", 0, 0, 0, 1, 0, 1);

    // Release S, then truncated frame that must time out.
    send_frame(8'hF0); send_frame(8'h1B);
    snap();
    tev.is_err = 1'b1; tev.b = 8'h00;
    evq.push_back(tev);
    send_bits(8'h1B, 1'b0, 1'b0, 5);
    waited = 0;
    while (err_cnt == s_err && waited < TO + 500) begin
      @(posedge clock);
      waited++;
    end
    check("timeout_fired", 32'(err_cnt - s_err), 32'd1);
    check("timeout_not_early", 32'(waited > TO - 50), 32'd1);
    check("timeout_not_late", 32'(waited < TO + 50), 32'd1);
    repeat (20) @(posedge clock);
    send_frame(8'h1B);
    delta("timeout", 0, 0, 0, 0, 1, 1);

    // Reset in the middle of a frame.
    send_bits(8'h72, 1'b0, 1'b0, 6);
    @(posedge clock);
    #2 resetn = 1'b0;
    repeat (10) @(posedge clock);
    #2 resetn = 1'b1;
    repeat (20) @(posedge clock);
    snap();
    send_frame(8'hE0); send_frame(8'h72);
    delta("after_reset", 0, 1, 0, 0, 0, 0);

    // Random traffic against the model.
    for (int n = 0; n < 30; n++) begin
      logic [7:0] b;
      int         k;
      k = $urandom_range(0, 7);
      b = (k == 7) ? 8'($urandom) : pool[k];
      k = $urandom_range(0, 9);
      send_frame(b, k == 0, k == 1);
    end

    repeat (20) @(posedge clock);
    check("all_events_seen", 32'(evq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Keyboard front end for the 2048 top level; sits directly upstream of `control`.
- Receives PS/2 frames from the keyboard and decodes scan-code set 2.
- Drives the game's `start` and 4-bit `direction` inputs as clean single-cycle pulses, replacing the temporary switch inputs.
- Suppresses typematic auto-repeat, so one physical press produces one move.

Parameters:
- FILTER_LEN, 8: consecutive equal synchronized samples required before the filtered ps2_clk level changes.
- TIMEOUT_CYCLES, 50000: idle ps2_clk-high cycles mid-frame before the frame is aborted (1 ms at 50 MHz).

Ports:
- clock  in  1  system clock (CLOCK_50 at top level).
- resetn  in  1  asynchronous, active-low reset.
- ps2_clk  in  1  raw PS/2 clock from the connector, asynchronous to `clock`.
- ps2_dat  in  1  raw PS/2 data from the connector, asynchronous to `clock`.
- direction  out  4  one-hot move pulse: [3]=up, [2]=down, [1]=left, [0]=right.
- start  out  1  one-cycle pulse on the S key press; feeds the game reset/start.
- rx_byte  out  8  last correctly received byte.
- rx_valid  out  1  one-cycle strobe; rx_byte is updated in the same cycle.
- frame_error  out  1  one-cycle pulse on parity error, bad start/stop bit, or timeout.

Behaviour:
- Reset (asynchronous, any time, including mid-frame):
  - direction=0, start=0, rx_byte=8'h00, rx_valid=0, frame_error=0.
  - Frame FSM goes to IDLE, decoder goes to BASE, all held flags cleared, filter/timeout counters cleared.
- Input conditioning:
  - ps2_clk and ps2_dat each pass through a 2-FF synchronizer.
  - ps2_clk is then glitch-filtered (FILTER_LEN agreement).
  - A bit is sampled from synchronized ps2_dat on the filtered falling edge only.
- Frame FSM, 11-bit frame, LSB first:
  - IDLE: on a falling edge, if dat=0 go to DATA; else pulse frame_error and stay in IDLE.
  - DATA: shift in 8 bits with a 3-bit counter, then go to PARITY.
  - PARITY: capture the bit, then go to STOP.
  - STOP: on a falling edge, check odd parity over data+parity and stop bit=1.
    - Pass: rx_byte and rx_valid are updated on the next clock (cycle T).
    - Fail: pulse frame_error at T; no rx_valid.
    - Either case: return to IDLE.
  - Timeout: in any non-IDLE state, filtered ps2_clk high for TIMEOUT_CYCLES consecutive cycles pulses frame_error and returns to IDLE. The counter restarts on every falling edge.
- Decoder FSM, advances only on rx_valid:
  - BASE:
    - E0 -> EXT.
    - F0 -> BRK.
    - 1B (S): if held_s=0, pulse start at T+1 and set held_s. Stay in BASE.
    - Any other byte is ignored; stay in BASE.
  - EXT:
    - F0 -> EXT_BRK.
    - 75 = up, 72 = down, 6B = left, 74 = right: if that key's held flag is 0, pulse the matching direction bit at T+1 and set the flag. Return to BASE.
    - Any other byte -> BASE, no output.
  - BRK: the next byte is always consumed as the released key. If 1B, clear held_s. Return to BASE.
  - EXT_BRK: the next byte is always consumed. If it is an arrow code, clear that arrow's held flag. Return to BASE.
  - A frame_error forces the decoder back to BASE; held flags are kept.
- Output guarantees:
  - Pulse latency is exactly one clock after rx_valid.
  - direction is never multi-hot; at most one pulse per frame.
  - start and direction are never asserted in the same cycle.
- Held-key rules:
  - Held flags are independent per key. Pressing left while up is held pulses left.
  - A repeated make code of a held key produces no pulse.

Decomposition:
- Shared package `ps2_defs`:
  - Scan-code constants: SC_EXT=8'hE0, SC_BRK=8'hF0, SC_S=8'h1B, SC_UP=8'h75, SC_DOWN=8'h72, SC_LEFT=8'h6B, SC_RIGHT=8'h74.
  - Direction bit indices DIR_UP=3, DIR_DOWN=2, DIR_LEFT=1, DIR_RIGHT=0.
  - Frame and decoder state encodings.
- One natural sub-module, `ps2_rx`:
  - Contains the synchronizer, filter, frame FSM and timeout.
  - Outputs rx_byte, rx_valid, frame_error.
  - The decoder FSM and held flags stay in ps2_key_decoder.

Test Plan:
- Frames E0 then 75 (correct odd parity) -> rx_valid twice; direction=4'b1000 for exactly one cycle, one clock after the second rx_valid; start stays 0.
- Frame 1B -> start one-cycle pulse. Then 1B again (typematic) -> no pulse. Then F0, 1B, 1B -> exactly one new start pulse.
- E0 6B, E0 6B, E0 F0 6B, E0 6B -> direction=4'b0010 pulses exactly twice (first and last make); no pulses for the repeat or the break.
- Frame 75 with the parity bit flipped -> frame_error pulse, rx_valid stays 0, rx_byte unchanged, no direction pulse. A following good E0 74 -> direction=4'b0001.
- 4 data bits sent, then ps2_clk held high for TIMEOUT_CYCLES -> frame_error at the timeout; the next full frame 1B -> start pulse.
- resetn low mid-frame (after 6 bits), released, then E0 72 -> all outputs 0 during reset; direction=4'b0100 after the frames.
